// File: rtl/rain_monitor.sv
// rain_monitor: multi-channel rain sensor debouncer with per-channel alarms,
// wet-channel count, storm flag, one-shot close request and an acknowledged
// sticky alarm. One independent debounce FSM per channel.

// Per-channel debounce FSM. Next-state terms are exported so the top can
// build its registered aggregate outputs on the same edge as the state.
module rain_monitor_ch #(
    parameter int DEBOUNCE = 4,
    parameter int DRY_HOLD = 8,
    parameter int CW       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_i,
    input  logic mask_i,
    output logic alarm_d_o,
    output logic enter_wet_o,
    output logic alarm_o
);
    typedef enum logic [1:0] {DRY, WET_PEND, WET, DRY_PEND} st_e;

    st_e           state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          alarm_q;

    assign cnt_inc = cnt_q + CW'(1);

    // Next state: count consecutive agreeing samples; any disagreeing
    // sample throws the window away. Mask overrides everything.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enter_wet_o = 1'b0;
        if (mask_i) begin
            state_d = DRY;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DRY: begin
                    cnt_d = '0;
                    if (sensor_i) begin
                        if (DEBOUNCE == 1) begin
                            state_d     = WET;
                            enter_wet_o = 1'b1;
                        end else begin
                            state_d = WET_PEND;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                WET_PEND: begin
                    if (!sensor_i) begin
                        state_d = DRY;
                        cnt_d   = '0;
                    end else if (cnt_inc == CW'(DEBOUNCE)) begin
                        state_d     = WET;
                        cnt_d       = '0;
                        enter_wet_o = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                WET: begin
                    cnt_d = '0;
                    if (!sensor_i) begin
                        if (DRY_HOLD == 1) begin
                            state_d = DRY;
                        end else begin
                            state_d = DRY_PEND;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                default: begin // DRY_PEND
                    if (sensor_i) begin
                        state_d = WET;
                        cnt_d   = '0;
                    end else if (cnt_inc == CW'(DRY_HOLD)) begin
                        state_d = DRY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            endcase
        end
    end

    assign alarm_d_o = (state_d == WET) || (state_d == DRY_PEND);
    assign alarm_o   = alarm_q;

    // State, counter and registered alarm flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DRY;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d_o;
        end
    end
endmodule

module rain_monitor #(
    parameter int CHANNELS = 4,
    parameter int DEBOUNCE = 4,
    parameter int DRY_HOLD = 8,
    parameter int STORM_TH = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS-1:0]           rain_sensor,
    input  logic [CHANNELS-1:0]           mask,
    input  logic                          ack,
    output logic [CHANNELS-1:0]           rain_alarm,
    output logic [$clog2(CHANNELS+1)-1:0] wet_count,
    output logic                          storm,
    output logic                          close_pulse,
    output logic                          alarm_latched
);
    localparam int MAXC = (DEBOUNCE > DRY_HOLD) ? DEBOUNCE : DRY_HOLD;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int WCW  = $clog2(CHANNELS + 1);

    logic [CHANNELS-1:0] alarm_d, enter_wet;
    logic [WCW-1:0]      wet_count_q, wet_count_d;
    logic                storm_q, close_q, latched_q, latched_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        rain_monitor_ch #(
            .DEBOUNCE(DEBOUNCE),
            .DRY_HOLD(DRY_HOLD),
            .CW      (CW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .sensor_i   (rain_sensor[g]),
            .mask_i     (mask[g]),
            .alarm_d_o  (alarm_d[g]),
            .enter_wet_o(enter_wet[g]),
            .alarm_o    (rain_alarm[g])
        );
    end

    // Population count of the next-cycle alarm vector.
    always_comb begin
        wet_count_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wet_count_d = wet_count_d + WCW'(alarm_d[i]);
        end
    end

    // Sticky alarm: a fresh wet entry wins over an acknowledge; ack only
    // clears once nothing is wet, and is not remembered otherwise.
    always_comb begin
        latched_d = latched_q;
        if (|enter_wet) begin
            latched_d = 1'b1;
        end else if (ack && (wet_count_d == '0)) begin
            latched_d = 1'b0;
        end
    end

    // Registered aggregate outputs, updated on the same edge as the FSMs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wet_count_q <= '0;
            storm_q     <= 1'b0;
            close_q     <= 1'b0;
            latched_q   <= 1'b0;
        end else begin
            wet_count_q <= wet_count_d;
            storm_q     <= (wet_count_d >= WCW'(STORM_TH));
            close_q     <= (wet_count_q == '0) && (wet_count_d != '0);
            latched_q   <= latched_d;
        end
    end

    assign wet_count     = wet_count_q;
    assign storm         = storm_q;
    assign close_pulse   = close_q;
    assign alarm_latched = latched_q;
endmodule
